divisor_secuencial: RTL and testbench

Parametrised sequential unsigned integer divider with a start/done handshake. It generalises the fixed combinational divide-by-2 used on the counter paths to any WIDTH and any runtime divisor. It computes quotient and remainder with a radix-2 restoring algorithm, one bit per clock. An optional single-cycle path handles power-of-two divisors. It serves the display/counter datapath wherever a counter value must be scaled by a runtime-selected factor.

---
 rtl/divisor_secuencial.sv | 148 ++++++++++++++
 tb/tb_divisor_secuencial.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// Sequential unsigned divider: radix-2 restoring, one quotient bit per clock,
// with single-cycle handling of divide-by-zero and (optionally) power-of-two divisors.
module divisor_secuencial #(
  parameter int WIDTH     = 11,
  parameter bit FAST_POW2 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             listo,
  output logic             ocupado,
  output logic             div_cero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [CW-1:0]    cnt_r;

  logic             accept_s, zero_s, pow2_s, last_s, ge_s;
  logic [CW-1:0]    shamt_s;
  logic [WIDTH-1:0] mask_s, rem_nx_s, quo_nx_s;
  logic [WIDTH:0]   rtrial_s, rdiff_s;

  // Request decode: accept condition, zero divisor, power-of-two detection and shift amount
  always_comb begin
    accept_s = inicio && ((state_r == IDLE) || (state_r == DONE));
    zero_s   = (divisor == ZERO_W);
    mask_s   = divisor - ONE_W;
    pow2_s   = FAST_POW2 && !zero_s && ((divisor & mask_s) == ZERO_W);
    shamt_s  = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (divisor[i]) begin
        shamt_s = CW'(i);
      end else begin
        shamt_s = shamt_s;
      end
    end
  end

  // One restoring step at WIDTH+1 bits so the subtract never overflows
  always_comb begin
    rtrial_s = {rem_r, quo_r[WIDTH-1]};
    rdiff_s  = rtrial_s - {1'b0, dvs_r};
    ge_s     = (rtrial_s >= {1'b0, dvs_r});
    if (ge_s) begin
      rem_nx_s = rdiff_s[WIDTH-1:0];
    end else begin
      rem_nx_s = rtrial_s[WIDTH-1:0];
    end
    quo_nx_s = {quo_r[WIDTH-2:0], ge_s};
    last_s   = (cnt_r == CNT_ONE);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (zero_s || pow2_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers and result registers; results only change on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r    <= ZERO_W;
      quo_r    <= ZERO_W;
      dvs_r    <= ZERO_W;
      cnt_r    <= {CW{1'b0}};
      cociente <= ZERO_W;
      residuo  <= ZERO_W;
      div_cero <= 1'b0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      listo   <= (state_s == DONE);
      ocupado <= (state_s == CALC);
      if (accept_s) begin
        rem_r <= ZERO_W;
        quo_r <= dividendo;
        dvs_r <= divisor;
        cnt_r <= CNT_INIT;
        if (zero_s) begin
          cociente <= ONES_W;
          residuo  <= dividendo;
          div_cero <= 1'b1;
        end else if (pow2_s) begin
          cociente <= dividendo >> shamt_s;
          residuo  <= dividendo & mask_s;
          div_cero <= 1'b0;
        end
      end else if (state_r == CALC) begin
        rem_r <= rem_nx_s;
        quo_r <= quo_nx_s;
        cnt_r <= cnt_r - CNT_ONE;
        if (last_s) begin
          cociente <= quo_nx_s;
          residuo  <= rem_nx_s;
          div_cero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: one instance with the power-of-two
// shortcut enabled and one without, both driven by the same stimulus.
module tb_divisor_secuencial;

  logic        clk = 1'b0;
  logic        rst_n, inicio;
  logic [10:0] dividendo, divisor;
  logic [10:0] c1, r1, c0, r0;
  logic        l1, o1, z1, l0, o0, z0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  divisor_secuencial #(.WIDTH(11), .FAST_POW2(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .dividendo(dividendo), .divisor(divisor),
    .cociente(c1), .residuo(r1), .listo(l1), .ocupado(o1), .div_cero(z1)
  );

  divisor_secuencial #(.WIDTH(11), .FAST_POW2(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .dividendo(dividendo), .divisor(divisor),
    .cociente(c0), .residuo(r0), .listo(l0), .ocupado(o0), .div_cero(z0)
  );

  // Present a one-cycle start request; returns at the falling edge of the cycle after the accept edge
  task automatic issue(input logic [10:0] a, input logic [10:0] b);
    @(negedge clk);
    dividendo = a;
    divisor   = b;
    inicio    = 1'b1;
    @(negedge clk);
    inicio    = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inicio = 1'b0; dividendo = 11'd0; divisor = 11'd0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({c1, r1, l1, o1, z1} !== 25'd0) begin n_bad++; $display("FAIL reset_fast: got %h want 0", {c1, r1, l1, o1, z1}); end
    n_cmp++; if ({c0, r0, l0, o0, z0} !== 25'd0) begin n_bad++; $display("FAIL reset_iter: got %h want 0", {c0, r0, l0, o0, z0}); end
    rst_n = 1'b1;
  endtask

  task automatic test_fast_pow2;
    int busy1, lcnt1, first0;
    issue(11'd4, 11'd2);
    n_cmp++; if (c1 !== 11'd2) begin n_bad++; $display("FAIL pow2_cociente: got %0d want 2", c1); end
    n_cmp++; if (r1 !== 11'd0) begin n_bad++; $display("FAIL pow2_residuo: got %0d want 0", r1); end
    n_cmp++; if (l1 !== 1'b1) begin n_bad++; $display("FAIL pow2_listo: got %b want 1", l1); end
    n_cmp++; if (z1 !== 1'b0) begin n_bad++; $display("FAIL pow2_div_cero: got %b want 0", z1); end
    busy1 = int'(o1); lcnt1 = 0; first0 = 0;
    for (int n = 2; n <= 14; n++) begin
      @(negedge clk);
      if (o1) busy1++;
      if (l1) lcnt1++;
      if (l0 && first0 == 0) first0 = n;
    end
    n_cmp++; if (busy1 !== 0) begin n_bad++; $display("FAIL pow2_ocupado: got %0d busy cycles want 0", busy1); end
    n_cmp++; if (lcnt1 !== 0) begin n_bad++; $display("FAIL pow2_listo_width: got %0d extra cycles want 0", lcnt1); end
    n_cmp++; if (first0 !== 12) begin n_bad++; $display("FAIL pow2_slow_latency: got %0d want 12", first0); end
    n_cmp++; if (c0 !== 11'd2) begin n_bad++; $display("FAIL pow2_slow_cociente: got %0d want 2", c0); end
  endtask

  task automatic test_iterative;
    int busy, first, lcnt, both;
    logic [10:0] cmid;
    busy = 0; first = 0; lcnt = 0; both = 0; cmid = 11'd0;
    issue(11'd1000, 11'd7);
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) @(negedge clk);
      if (o1) busy++;
      if (l1) begin lcnt++; if (first == 0) first = n; end
      if (o1 && l1) both++;
      if (n == 5) cmid = c1;
    end
    n_cmp++; if (busy !== 11) begin n_bad++; $display("FAIL iter_busy: got %0d want 11", busy); end
    n_cmp++; if (first !== 12) begin n_bad++; $display("FAIL iter_latency: got %0d want 12", first); end
    n_cmp++; if (lcnt !== 1) begin n_bad++; $display("FAIL iter_listo_count: got %0d want 1", lcnt); end
    n_cmp++; if (both !== 0) begin n_bad++; $display("FAIL iter_overlap: got %0d want 0", both); end
    n_cmp++; if (cmid !== 11'd2) begin n_bad++; $display("FAIL iter_hold: got %0d want 2", cmid); end
    n_cmp++; if (c1 !== 11'd142) begin n_bad++; $display("FAIL iter_cociente: got %0d want 142", c1); end
    n_cmp++; if (r1 !== 11'd6) begin n_bad++; $display("FAIL iter_residuo: got %0d want 6", r1); end
    n_cmp++; if (z1 !== 1'b0) begin n_bad++; $display("FAIL iter_div_cero: got %b want 0", z1); end
  endtask

  task automatic test_div_zero;
    issue(11'd100, 11'd0);
    n_cmp++; if (c1 !== 11'd2047) begin n_bad++; $display("FAIL dz_cociente: got %0d want 2047", c1); end
    n_cmp++; if (r1 !== 11'd100) begin n_bad++; $display("FAIL dz_residuo: got %0d want 100", r1); end
    n_cmp++; if (z1 !== 1'b1) begin n_bad++; $display("FAIL dz_div_cero: got %b want 1", z1); end
    n_cmp++; if (l1 !== 1'b1 || o1 !== 1'b0) begin n_bad++; $display("FAIL dz_listo_ocupado: got %b%b want 10", l1, o1); end
    n_cmp++; if ({c0, r0, z0, l0} !== {11'd2047, 11'd100, 1'b1, 1'b1}) begin n_bad++; $display("FAIL dz_slow: got %0d r %0d z %b l %b want 2047 r 100 z 1 l 1", c0, r0, z0, l0); end
    @(negedge clk);
    n_cmp++; if (l1 !== 1'b0) begin n_bad++; $display("FAIL dz_listo_width: got %b want 0", l1); end
  endtask

  task automatic test_pow2_one;
    int first0;
    first0 = 0;
    issue(11'd2047, 11'd1);
    n_cmp++; if ({c1, r1, l1, z1} !== {11'd2047, 11'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL div1_fast: got %0d r %0d l %b z %b want 2047 r 0 l 1 z 0", c1, r1, l1, z1); end
    for (int n = 2; n <= 14; n++) begin
      @(negedge clk);
      if (l0 && first0 == 0) first0 = n;
    end
    n_cmp++; if (first0 !== 12) begin n_bad++; $display("FAIL div1_slow_latency: got %0d want 12", first0); end
    n_cmp++; if ({c0, r0, z0} !== {11'd2047, 11'd0, 1'b0}) begin n_bad++; $display("FAIL div1_slow: got %0d r %0d z %b want 2047 r 0 z 0", c0, r0, z0); end
  endtask

  task automatic test_back_to_back;
    int lcnt_a, lcnt_b, first_b;
    logic [10:0] c_a, r_a;
    logic o13;
    lcnt_a = 0; lcnt_b = 0; first_b = 0; c_a = 11'd0; r_a = 11'd0; o13 = 1'b0;
    issue(11'd1000, 11'd7);
    for (int n = 1; n <= 26; n++) begin
      if (n > 1) @(negedge clk);
      if (l1) begin
        if (n <= 12) lcnt_a++;
        else begin lcnt_b++; if (first_b == 0) first_b = n; end
      end
      if (n == 12) begin c_a = c1; r_a = r1; end
      if (n == 13) o13 = o1;
      if (n == 4 || n == 11) begin inicio = 1'b1; dividendo = 11'd50; divisor = 11'd5; end
      if (n == 5 || n == 13) inicio = 1'b0;
    end
    n_cmp++; if (lcnt_a !== 1) begin n_bad++; $display("FAIL b2b_first_listo: got %0d want 1", lcnt_a); end
    n_cmp++; if ({c_a, r_a} !== {11'd142, 11'd6}) begin n_bad++; $display("FAIL b2b_ignored: got %0d r %0d want 142 r 6", c_a, r_a); end
    n_cmp++; if (o13 !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got %b want 1", o13); end
    n_cmp++; if (first_b !== 24 || lcnt_b !== 1) begin n_bad++; $display("FAIL b2b_second_listo: got cycle %0d count %0d want 24 1", first_b, lcnt_b); end
    n_cmp++; if ({c1, r1} !== {11'd10, 11'd0}) begin n_bad++; $display("FAIL b2b_result: got %0d r %0d want 10 r 0", c1, r1); end
  endtask

  task automatic test_reset_mid;
    int lcnt, first;
    logic o_new;
    lcnt = 0; first = 0;
    issue(11'd1000, 11'd7);
    for (int n = 2; n <= 5; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({c1, r1, l1, o1, z1} !== 25'd0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h want 0", {c1, r1, l1, o1, z1}); end
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (n == 2) rst_n = 1'b1;
      if (l1 || l0) lcnt++;
    end
    n_cmp++; if (lcnt !== 0) begin n_bad++; $display("FAIL rst_mid_no_listo: got %0d pulses want 0", lcnt); end
    issue(11'd9, 11'd3);
    o_new = o1;
    for (int n = 2; n <= 14; n++) begin
      @(negedge clk);
      if (l1 && first == 0) first = n;
    end
    n_cmp++; if (o_new !== 1'b1 || first !== 12) begin n_bad++; $display("FAIL rst_mid_new_op: got ocupado %b latency %0d want 1 12", o_new, first); end
    n_cmp++; if ({c1, r1, z1} !== {11'd3, 11'd0, 1'b0}) begin n_bad++; $display("FAIL rst_mid_result: got %0d r %0d z %b want 3 r 0 z 0", c1, r1, z1); end
  endtask

  initial begin
    test_reset();
    test_fast_pow2();
    test_iterative();
    test_div_zero();
    test_pow2_one();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
